fifo_gen: RTL and testbench

FIFO_GEN -- requirements
Module: fifo_gen

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_gen.sv | 101 ++++++++++
 tb/tb_fifo_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the fifo_gen FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Occupancy counter width: it must hold 0..2**addr_w inclusive.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    // Combinational read gives first-word-fall-through at the head pointer.
    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_gen.sv
// Synchronous FWFT FIFO: pointer, occupancy and sticky error logic around fifo_ram.
module fifo_gen
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_LVL = (2**ADDR_W) - 1,
    parameter int AE_LVL = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr,
    input  logic [DATA_W-1:0]           w_data,
    input  logic                        rd,
    output logic [DATA_W-1:0]           r_data,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [cnt_w(ADDR_W)-1:0]    count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int CW    = cnt_w(ADDR_W);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [ADDR_W-1:0] w_ptr_reg;
    logic [ADDR_W-1:0] r_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              rd_ok;
    logic              wr_ok;

    // Flags come only from the registered count, never from wr/rd.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_C);
    assign almost_empty = (count_reg <= AE_C);
    assign almost_full  = (count_reg >= AF_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot this cycle, so a write into a full FIFO still fits.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    always_comb begin
        count_next = count_reg;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr_reg <= w_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                r_ptr_reg <= r_ptr_reg + 1'b1;
            end
            count_reg     <= count_next;
            overflow_reg  <= overflow_reg  | (wr && !wr_ok);
            underflow_reg <= underflow_reg | (rd && empty);
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we     (wr_ok && !clr),
        .w_addr (w_ptr_reg),
        .w_data (w_data),
        .r_addr (r_ptr_reg),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_fifo_gen.sv
// Self-checking bench for fifo_gen (depth 4): vector table plus hand-written corner sequences.
module tb_fifo_gen;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    int mq[$];

    typedef struct {
        logic       c;
        logic       w;
        logic       r;
        logic [7:0] d;
        int         cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vt[$];

    fifo_gen #(
        .DATA_W (8),
        .ADDR_W (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic st(input string tag, input int c, input logic o, input logic u);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".empty"}, int'(empty), int'(c == 0));
        chk({tag, ".full"}, int'(full), int'(c == DEPTH));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(c <= 1));
        chk({tag, ".almost_full"}, int'(almost_full), int'(c >= DEPTH - 1));
        chk({tag, ".overflow"}, int'(overflow), int'(o));
        chk({tag, ".underflow"}, int'(underflow), int'(u));
        $display("%s: count=%0d empty=%0b full=%0b ae=%0b af=%0b ovf=%0b unf=%0b",
                 tag, count, empty, full, almost_empty, almost_full, overflow, underflow);
    endtask

    // One clock: drive inputs, pop/compare head if a read is accepted, then update the model.
    task automatic cycle(input logic c, input logic w, input logic r, input logic [7:0] d);
        bit rok;
        bit wok;
        int exp;
        clr = c;
        wr = w;
        rd = r;
        w_data = d;
        #1;
        rok = r && (mq.size() > 0);
        wok = w && ((mq.size() < DEPTH) || rok);
        if (!c && rok) begin
            exp = mq.pop_front();
            chk("r_data", int'(r_data), exp);
        end
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
        end else if (wok) begin
            mq.push_back(int'(d));
        end
        clr = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    function automatic void add(input logic c, input logic w, input logic r, input logic [7:0] d,
                                input int cnt, input logic o, input logic u);
        vec_t v;
        v.c = c; v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.ovf = o; v.unf = u;
        vt.push_back(v);
    endfunction

    initial begin
        // clr wr rd data  count ovf unf
        add(0, 1, 0, 8'd3, 1, 0, 0);   // write 3 then 5, read both
        add(0, 1, 0, 8'd5, 2, 0, 0);
        add(0, 0, 1, 8'd0, 1, 0, 0);
        add(0, 0, 1, 8'd0, 0, 0, 0);
        add(0, 0, 1, 8'd0, 0, 0, 1);   // read on empty
        add(0, 0, 0, 8'd0, 0, 0, 1);   // sticky
        add(1, 1, 1, 8'd77, 0, 0, 0);  // clr overrides wr/rd
        add(0, 1, 0, 8'd1, 1, 0, 0);   // fill to full
        add(0, 1, 0, 8'd2, 2, 0, 0);
        add(0, 1, 0, 8'd3, 3, 0, 0);
        add(0, 1, 0, 8'd4, 4, 0, 0);
        add(0, 1, 0, 8'd6, 4, 1, 0);   // fifth write dropped
        add(0, 1, 1, 8'd9, 4, 1, 0);   // full, simultaneous rd/wr
        add(0, 0, 1, 8'd0, 3, 1, 0);
        add(0, 0, 1, 8'd0, 2, 1, 0);
        add(0, 0, 1, 8'd0, 1, 1, 0);
        add(0, 0, 1, 8'd0, 0, 1, 0);   // 9 comes out last
        add(1, 0, 0, 8'd0, 0, 0, 0);
        add(0, 1, 1, 8'd7, 1, 0, 1);   // empty, simultaneous rd/wr
        add(0, 0, 1, 8'd0, 0, 0, 1);
        add(1, 0, 0, 8'd0, 0, 0, 0);

        #2;
        st("reset", 0, 0, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].c, vt[i].w, vt[i].r, vt[i].d);
            st($sformatf("vec%0d", i), vt[i].cnt, vt[i].ovf, vt[i].unf);
        end

        // Lockstep write/read pairs: ten words walk both pointers around twice.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 8'(i));
            st($sformatf("pair%0d.wr", i), 1, 0, 0);
            cycle(0, 0, 1, 8'd0);
            st($sformatf("pair%0d.rd", i), 0, 0, 0);
        end

        // Asynchronous reset between edges discards stored words immediately.
        cycle(0, 1, 0, 8'h11);
        cycle(0, 1, 0, 8'h22);
        st("pre_rst", 2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        st("async_rst", 0, 0, 0);
        mq.delete();
        #1 rst_n = 1'b1;
        cycle(0, 1, 0, 8'hA1);
        st("post_rst.wr", 1, 0, 0);
        cycle(0, 0, 1, 8'd0);
        st("post_rst.rd", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
